// File: rtl/riscv_pkg.sv
// Shared RISC-V core definitions: opcodes, the hazard tracker entry and the
// forwarding-select width helper used by hazard_unit and control_logic.
package riscv_pkg;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;

    // Widest register address the tracker entry can hold; narrower rd is zero-extended.
    localparam int unsigned REG_AW_MAX = 8;

    typedef struct packed {
        logic                  valid;
        logic [REG_AW_MAX-1:0] rd;
        logic                  wen;
        logic                  is_load;
    } hazard_entry_t;

    function automatic int unsigned fwd_sel_w(input int unsigned nstage);
        return (nstage < 1) ? 1 : $clog2(nstage + 1);
    endfunction

endpackage

// File: rtl/hazard_match.sv
// Youngest-match priority encoder for one source operand over the tracker.
// sel = stage of the youngest valid writer of rs (0 = none).
module hazard_match
    import riscv_pkg::*;
#(
    parameter int unsigned NSTAGE = 3,
    parameter int unsigned REG_AW = 5,
    parameter int unsigned SEL_W  = fwd_sel_w(NSTAGE)
) (
    input  logic [REG_AW-1:0] rs,
    input  logic              uses,
    input  hazard_entry_t     entries [NSTAGE],
    output logic [SEL_W-1:0]  sel,
    output logic              is_load_hit
);

    logic [REG_AW_MAX-1:0] rs_ext;

    // Scan oldest to youngest so the lowest matching stage is the final winner.
    always_comb begin
        rs_ext              = '0;
        rs_ext[REG_AW-1:0]  = rs;
        sel                 = '0;
        is_load_hit         = 1'b0;
        if (uses && (rs != '0)) begin
            for (int unsigned k = NSTAGE; k > 0; k--) begin
                if (entries[k-1].valid && entries[k-1].wen && (entries[k-1].rd == rs_ext)) begin
                    sel         = SEL_W'(k);
                    is_load_hit = (k == 1) && entries[0].is_load;
                end
            end
        end
    end

endmodule

// File: rtl/hazard_unit.sv
// Hazard/forwarding controller: EX..WB tracker, operand forwarding selects,
// load-use stall and redirect flush. Optional forwarding via HAZARD_FWD_EN.
module hazard_unit
    import riscv_pkg::*;
#(
    parameter int unsigned NSTAGE       = 3,
    parameter int unsigned REG_AW       = 5,
    parameter int unsigned FLUSH_CYCLES = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         id_valid_i,
    input  logic [REG_AW-1:0]            id_rs1_i,
    input  logic [REG_AW-1:0]            id_rs2_i,
    input  logic                         id_uses_rs1_i,
    input  logic                         id_uses_rs2_i,
    input  logic [REG_AW-1:0]            id_rd_i,
    input  logic                         id_wen_i,
    input  logic                         id_is_load_i,
    input  logic                         ex_redirect_i,
    output logic                         stall_o,
    output logic                         flush_o,
    output logic                         issue_o,
    output logic [fwd_sel_w(NSTAGE)-1:0] fwd_a_sel_o,
    output logic [fwd_sel_w(NSTAGE)-1:0] fwd_b_sel_o
);

    localparam int unsigned SEL_W = fwd_sel_w(NSTAGE);
    localparam int unsigned CNT_W = $clog2(FLUSH_CYCLES + 1);

    hazard_entry_t     trk [NSTAGE];
    hazard_entry_t     id_entry;
    logic [CNT_W-1:0]  flush_cnt;
    logic [SEL_W-1:0]  sel_a, sel_b;
    logic              hit_a, hit_b;
    logic              raw_stall;

    hazard_match #(.NSTAGE(NSTAGE), .REG_AW(REG_AW), .SEL_W(SEL_W)) u_match_a (
        .rs          (id_rs1_i),
        .uses        (id_uses_rs1_i),
        .entries     (trk),
        .sel         (sel_a),
        .is_load_hit (hit_a)
    );

    hazard_match #(.NSTAGE(NSTAGE), .REG_AW(REG_AW), .SEL_W(SEL_W)) u_match_b (
        .rs          (id_rs2_i),
        .uses        (id_uses_rs2_i),
        .entries     (trk),
        .sel         (sel_b),
        .is_load_hit (hit_b)
    );

`ifndef HAZARD_FWD_EN
    logic unused_load_hit;
    assign unused_load_hit = hit_a | hit_b;
`endif

    always_comb begin
        id_entry                = '0;
        id_entry.valid          = 1'b1;
        id_entry.rd[REG_AW-1:0] = id_rd_i;
        id_entry.wen            = id_wen_i;
        id_entry.is_load        = id_is_load_i;

        fwd_a_sel_o = '0;
        fwd_b_sel_o = '0;
`ifdef HAZARD_FWD_EN
        raw_stall = hit_a | hit_b;
        if (!rst) begin
            fwd_a_sel_o = sel_a;
            fwd_b_sel_o = sel_b;
        end
`else
        // Without forwarding, any in-flight writer blocks the consumer until it retires.
        raw_stall = (sel_a != '0) || (sel_b != '0);
`endif
        flush_o = !rst && (ex_redirect_i || (flush_cnt != '0));
        stall_o = !rst && !flush_o && raw_stall;
        issue_o = !rst && id_valid_i && !stall_o && !flush_o;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned k = 0; k < NSTAGE; k++) begin
                trk[k] <= '0;
            end
        end else begin
            trk[0] <= issue_o ? id_entry : '0;
            for (int unsigned k = 1; k < NSTAGE; k++) begin
                trk[k] <= trk[k-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            flush_cnt <= '0;
        end else if (ex_redirect_i) begin
            flush_cnt <= CNT_W'(FLUSH_CYCLES - 1);
        end else if (flush_cnt != '0) begin
            flush_cnt <= flush_cnt - 1'b1;
        end
    end

endmodule

// File: tb/tb_hazard_unit.sv
// Randomised and directed bench for hazard_unit against an in-flight
// instruction list model; follows HAZARD_FWD_EN like the design.
module tb_hazard_unit;

    localparam int NS = 3;
    localparam int AW = 5;
    localparam int FC = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          id_valid_i;
    logic [AW-1:0] id_rs1_i, id_rs2_i, id_rd_i;
    logic          id_uses_rs1_i, id_uses_rs2_i;
    logic          id_wen_i, id_is_load_i, ex_redirect_i;
    logic          stall_o, flush_o, issue_o;
    logic [1:0]    fwd_a_sel_o, fwd_b_sel_o;

    hazard_unit #(.NSTAGE(NS), .REG_AW(AW), .FLUSH_CYCLES(FC)) dut (
        .clk           (clk),
        .rst           (rst),
        .id_valid_i    (id_valid_i),
        .id_rs1_i      (id_rs1_i),
        .id_rs2_i      (id_rs2_i),
        .id_uses_rs1_i (id_uses_rs1_i),
        .id_uses_rs2_i (id_uses_rs2_i),
        .id_rd_i       (id_rd_i),
        .id_wen_i      (id_wen_i),
        .id_is_load_i  (id_is_load_i),
        .ex_redirect_i (ex_redirect_i),
        .stall_o       (stall_o),
        .flush_o       (flush_o),
        .issue_o       (issue_o),
        .fwd_a_sel_o   (fwd_a_sel_o),
        .fwd_b_sel_o   (fwd_b_sel_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          valid;
        int unsigned rd;
        bit          wen;
        bit          load;
    } inflight_t;

    inflight_t pipe [1:NS];
    int        cyc;
    int        flush_end;
    bit        last_issue;
    int        n_tests = 0;
    int        n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s cyc=%0d got=%0d expected=%0d", tag, cyc, got, exp);
        end
    endtask

    // Stage number of the youngest in-flight writer of rs, 0 if none.
    function automatic int unsigned youngest(input int unsigned rs, input bit uses);
        if (!uses || rs == 0) return 0;
        for (int k = 1; k <= NS; k++)
            if (pipe[k].valid && pipe[k].wen && pipe[k].rd == rs) return k;
        return 0;
    endfunction

    task automatic cycle(input bit r, input bit v, input int unsigned rs1, input int unsigned rs2,
                         input bit u1, input bit u2, input int unsigned rd, input bit wen,
                         input bit ld, input bit redir);
        int unsigned ka, kb, ea, eb;
        bit e_flush, e_stall, e_issue;
        rst = r; id_valid_i = v; id_rs1_i = AW'(rs1); id_rs2_i = AW'(rs2);
        id_uses_rs1_i = u1; id_uses_rs2_i = u2; id_rd_i = AW'(rd);
        id_wen_i = wen; id_is_load_i = ld; ex_redirect_i = redir;
        #2;
        ka = youngest(rs1, u1);
        kb = youngest(rs2, u2);
        e_flush = !r && (redir || cyc <= flush_end);
`ifdef HAZARD_FWD_EN
        e_stall = !r && !e_flush && pipe[1].load && (ka == 1 || kb == 1);
        ea = r ? 0 : ka;
        eb = r ? 0 : kb;
`else
        e_stall = !r && !e_flush && (ka != 0 || kb != 0);
        ea = 0;
        eb = 0;
`endif
        e_issue = !r && v && !e_stall && !e_flush;
        check("flush", 32'(flush_o), 32'(e_flush));
        check("stall", 32'(stall_o), 32'(e_stall));
        check("issue", 32'(issue_o), 32'(e_issue));
        check("fwd_a", 32'(fwd_a_sel_o), ea);
        check("fwd_b", 32'(fwd_b_sel_o), eb);
        last_issue = e_issue;
        @(posedge clk);
        if (r) begin
            for (int k = 1; k <= NS; k++) pipe[k] = '{default: 0};
            flush_end = -1;
        end else begin
            if (redir) flush_end = cyc + FC - 1;
            for (int k = NS; k >= 2; k--) pipe[k] = pipe[k-1];
            pipe[1] = e_issue ? '{valid: 1'b1, rd: rd, wen: wen, load: ld} : '{default: 0};
        end
        cyc++;
        #1;
    endtask

    task automatic idle(input bit v);
        cycle(0, v, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    // Present one instruction until it issues; bounded so a stuck stall cannot hang.
    task automatic issue_inst(input int unsigned rs1, input int unsigned rs2, input bit u1,
                              input bit u2, input int unsigned rd, input bit wen, input bit ld);
        int n = 0;
        do begin
            cycle(0, 1, rs1, rs2, u1, u2, rd, wen, ld, 0);
            n++;
        end while (!last_issue && n < 8);
        if (!last_issue) check("issue_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        cyc = 0;
        flush_end = -1;
        for (int k = 1; k <= NS; k++) pipe[k] = '{default: 0};
        rst = 1'b1; id_valid_i = 0; id_rs1_i = 0; id_rs2_i = 0; id_rd_i = 0;
        id_uses_rs1_i = 0; id_uses_rs2_i = 0; id_wen_i = 0; id_is_load_i = 0; ex_redirect_i = 0;
        @(posedge clk); #1;
        cycle(1, 1, 5, 6, 1, 1, 7, 1, 1, 1);
        cycle(1, 1, 0, 0, 0, 0, 0, 0, 0, 0);

        // add x5 ; add x6,x5,x1
        issue_inst(1, 2, 1, 1, 5, 1, 0);
        issue_inst(5, 1, 1, 1, 6, 1, 0);
        repeat (3) idle(0);

        // lw x5 ; add x7,x5,x5
        issue_inst(1, 0, 1, 0, 5, 1, 1);
        issue_inst(5, 5, 1, 1, 7, 1, 0);
        repeat (3) idle(0);

        // x0 producer then x0 consumer
        issue_inst(1, 0, 1, 0, 0, 1, 1);
        issue_inst(0, 0, 1, 1, 8, 1, 0);
        repeat (3) idle(0);

        // Single redirect, then a redirect on the second flush cycle
        cycle(0, 1, 0, 0, 0, 0, 9, 1, 0, 1);
        repeat (3) idle(1);
        cycle(0, 1, 0, 0, 0, 0, 9, 1, 0, 1);
        cycle(0, 1, 0, 0, 0, 0, 9, 1, 0, 1);
        repeat (3) idle(1);

        // x5 written twice back to back, then read
        issue_inst(1, 2, 1, 1, 5, 1, 0);
        issue_inst(3, 4, 1, 1, 5, 1, 0);
        cycle(0, 1, 5, 5, 1, 1, 10, 1, 0, 0);
        repeat (3) idle(0);

        // Reset in the middle of a load-use stall
        issue_inst(1, 0, 1, 0, 5, 1, 1);
        cycle(0, 1, 5, 0, 1, 0, 11, 1, 0, 0);
        cycle(1, 1, 5, 0, 1, 0, 11, 1, 0, 0);
        cycle(0, 1, 5, 5, 1, 1, 11, 1, 0, 0);
        repeat (3) idle(0);

        for (int i = 0; i < 600; i++) begin
            cycle(($urandom_range(0, 99) < 2), ($urandom_range(0, 9) < 8),
                  $urandom_range(0, 7), $urandom_range(0, 7),
                  ($urandom_range(0, 3) != 0), ($urandom_range(0, 3) != 0),
                  $urandom_range(0, 7), ($urandom_range(0, 9) < 8),
                  ($urandom_range(0, 9) < 3), ($urandom_range(0, 9) < 1));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/hazard_unit.md
# hazard_unit

Parametrised hazard and forwarding controller for the pipelined RISC-V core. It sits beside decode and tracks every in-flight instruction from EX to WB in a shift register. Each cycle it drives the operand-forwarding selects, the load-use stall and the post-redirect flush. It generalises the fixed one-stage forwarding of the current control logic to a configurable pipeline depth and adds stall and flush handling.

## Interface
Parameters:
- NSTAGE, default 3: number of tracked stages after ID. Stage 1 is EX; stage NSTAGE is WB.
- REG_AW, default 5: register address width.
- FLUSH_CYCLES, default 2: number of cycles flush_o stays high per redirect (≥1).

Ports:
- clk  in  1  main clock
- rst  in  1  reset; synchronous, active-high; clock clk
- id_valid_i  in  1  ID holds a real instruction
- id_rs1_i / id_rs2_i  in  REG_AW  source registers
- id_uses_rs1_i / id_uses_rs2_i  in  1  operand actually read
- id_rd_i  in  REG_AW  destination register
- id_wen_i  in  1  instruction writes rd
- id_is_load_i  in  1  instruction is a load
- ex_redirect_i  in  1  taken branch or jump resolved in EX
- stall_o  out  1  hold PC and IF/ID; inject bubble into EX
- flush_o  out  1  kill the IF/ID contents
- issue_o  out  1  ID instruction enters EX this cycle
- fwd_a_sel_o / fwd_b_sel_o  out  $clog2(NSTAGE+1)  0 = register file, k = result of stage k

## Operation
- Tracker: NSTAGE entries, each holding {valid, rd, wen, is_load}. On every non-reset posedge, entry k moves to k+1 and the last entry is discarded.
  - Entry 1 loads the ID fields when issue_o = 1.
  - Otherwise entry 1 loads a bubble (valid = 0).
- issue_o = id_valid_i & !stall_o & !flush_o.
- Operand match, evaluated independently for rs1 and rs2:
  - A source is considered only when its uses bit is 1 and the register is not x0.
  - Match candidates are entries with valid & wen & rd == rs.
  - The youngest match (lowest k) wins.
  - sel = k of the winner, or 0 if there is no match.
- Load-use: stall_o = 1 if either operand's youngest match is entry 1 with is_load = 1. Load data is forwardable from stage 2 onward.
- Flush:
  - When ex_redirect_i = 1, flush_o = 1 that cycle and the counter loads FLUSH_CYCLES-1.
  - While the counter is non-zero, flush_o = 1 and the counter decrements.
  - A redirect during a flush reloads the counter.
  - The redirecting instruction in entry 1 is never killed.
- Priority: flush over stall. stall_o = 0 whenever flush_o = 1.
- Boundaries:
  - Producer in entry NSTAGE: forwarded this cycle, gone next cycle.
  - Same rd in several entries: youngest wins.
  - rs1 == rs2: both selects are identical.

## Timing
- stall_o, flush_o, issue_o and fwd_*_sel_o are combinational from tracker state and same-cycle ID inputs. Tracker and counter update at posedge clk.
- Load-use costs exactly 1 bubble. Redirect costs FLUSH_CYCLES killed slots.
- While rst = 1, all outputs are 0. On the first posedge with rst high, the tracker is invalidated and the counter cleared, including mid-flush or mid-stall. The first cycle after rst low has no stall or flush.

## Configuration
- HAZARD_FWD_EN defined: forwarding as described above.
- HAZARD_FWD_EN undefined:
  - fwd_a_sel_o and fwd_b_sel_o are tied to 0.
  - stall_o = 1 whenever any matching entry exists in stages 1..NSTAGE, regardless of is_load. The register file has no write-through.
  - Flush behaviour is unchanged.

## Structure
- riscv_pkg holds the opcode constants, the hazard_entry_t struct and the forwarding-select width function. These are shared with control_logic.
- One sub-module, hazard_match: a per-operand youngest-match priority encoder that outputs sel and is_load_hit. It is instantiated twice.

## Test plan
- add x5 issues; add x6,x5,x1 next cycle → fwd_a_sel_o = 1, fwd_b_sel_o = 0, stall_o = 0.
- lw x5 issues; add x7,x5,x5 next cycle → stall_o = 1 for 1 cycle, then issue_o = 1 with both selects = 2.
- Producer writes x0; consumer reads x0 → selects 0, no stall.
- ex_redirect_i pulses for 1 cycle with FLUSH_CYCLES = 2 → flush_o high for 2 cycles, issue_o = 0, two bubbles enter EX. A second pulse in cycle 2 extends the flush to 3 cycles.
- x5 written by entries 1 and 2 (neither a load) → sel = 1. rst asserted mid-stall → all outputs 0 and tracker empty the cycle after.
- HAZARD_FWD_EN undefined, NSTAGE = 3: add x5 then add x6,x5 → stall_o high for 3 cycles, then issue with sel = 0.
